// File: rtl/psc_timebase_if.sv
// Prescaler timebase control/status bundle.
// master drives control, slave (the timebase) drives status.
interface psc_timebase_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             psc_we;
  logic [WIDTH-1:0] psc_wdata;
  logic             ug;
  logic             tick;
  logic             tgl;
  logic [WIDTH-1:0] psc_cnt;
  logic [WIDTH-1:0] psc_shadow;
  logic             upd_pend;

  modport master (
    output en, psc_we, psc_wdata, ug,
    input  tick, tgl, psc_cnt, psc_shadow, upd_pend
  );

  modport slave (
    input  en, psc_we, psc_wdata, ug,
    output tick, tgl, psc_cnt, psc_shadow, upd_pend
  );
endinterface

// File: rtl/psc_timebase.sv
// Prescaler timebase: clock-enable tick at divide ratio shadow+1,
// with optional preload buffering of the divide value.
module psc_timebase #(
  parameter int WIDTH      = 16,
  parameter bit PRELOAD_EN = 1'b1
) (
  input logic         clk,
  input logic         rst,
  psc_timebase_if.slave bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow;
  logic             tgl_q;
  logic             tick;
  logic             xfer;

  // >= rather than == so a shrinking shadow never causes a full wrap
  assign tick = bus.en & ~bus.ug & (cnt >= shadow);
  assign xfer = tick | bus.ug;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (bus.ug) begin
      cnt <= '0;
    end else if (bus.en) begin
      cnt <= tick ? '0 : cnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgl_q <= 1'b0;
    end else if (tick) begin
      tgl_q <= ~tgl_q;
    end
  end

  if (PRELOAD_EN) begin : g_pre
    logic [WIDTH-1:0] preload;
    logic             pend;

    // a write racing a transfer lands in preload and stays pending
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        preload <= '0;
        shadow  <= '0;
        pend    <= 1'b0;
      end else begin
        if (bus.psc_we) preload <= bus.psc_wdata;
        if (xfer)       shadow  <= preload;
        if (bus.psc_we) pend    <= 1'b1;
        else if (xfer)  pend    <= 1'b0;
      end
    end

    assign bus.upd_pend = pend;
  end else begin : g_dir
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow <= '0;
      end else if (bus.psc_we) begin
        shadow <= bus.psc_wdata;
      end
    end

    assign bus.upd_pend = 1'b0;
  end

  assign bus.tick       = tick;
  assign bus.tgl        = tgl_q;
  assign bus.psc_cnt    = cnt;
  assign bus.psc_shadow = shadow;

endmodule

// File: tb/tb_psc_timebase.sv
// Bench for psc_timebase: directed scenarios plus random traffic
// against a per-instance behavioural model.
module tb_psc_timebase;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, we, ug;
  logic [15:0] wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psc_timebase_if #(.WIDTH(16)) ifa ();
  psc_timebase_if #(.WIDTH(16)) ifb ();
  psc_timebase_if #(.WIDTH(4))  ifc ();

  assign ifa.en = en;
  assign ifa.psc_we = we;
  assign ifa.psc_wdata = wd;
  assign ifa.ug = ug;
  assign ifb.en = en;
  assign ifb.psc_we = we;
  assign ifb.psc_wdata = wd;
  assign ifb.ug = ug;
  assign ifc.en = en;
  assign ifc.psc_we = we;
  assign ifc.psc_wdata = wd[3:0];
  assign ifc.ug = ug;

  psc_timebase #(.WIDTH(16), .PRELOAD_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  psc_timebase #(.WIDTH(16), .PRELOAD_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );
  psc_timebase #(.WIDTH(4), .PRELOAD_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  logic [15:0] o_cnt [3];
  logic [15:0] o_sh  [3];
  logic        o_tick[3];
  logic        o_tgl [3];
  logic        o_pend[3];

  assign o_cnt[0] = ifa.psc_cnt;
  assign o_cnt[1] = ifb.psc_cnt;
  assign o_cnt[2] = {12'd0, ifc.psc_cnt};
  assign o_sh[0] = ifa.psc_shadow;
  assign o_sh[1] = ifb.psc_shadow;
  assign o_sh[2] = {12'd0, ifc.psc_shadow};
  assign o_tick[0] = ifa.tick;
  assign o_tick[1] = ifb.tick;
  assign o_tick[2] = ifc.tick;
  assign o_tgl[0] = ifa.tgl;
  assign o_tgl[1] = ifb.tgl;
  assign o_tgl[2] = ifc.tgl;
  assign o_pend[0] = ifa.upd_pend;
  assign o_pend[1] = ifb.upd_pend;
  assign o_pend[2] = ifc.upd_pend;

  // behavioural model, one slot per instance
  int unsigned m_cnt[3], m_pre[3], m_sh[3], m_msk[3];
  bit          m_tgl[3], m_pend[3], m_pre_en[3];

  function automatic bit m_tick(int k);
    return (en === 1'b1) && (ug !== 1'b1) && (m_cnt[k] >= m_sh[k]);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_pre[k] = 0;
      m_sh[k] = 0;
      m_tgl[k] = 0;
      m_pend[k] = 0;
      m_msk[k] = (k == 2) ? 32'd15 : 32'd65535;
      m_pre_en[k] = (k != 1);
    end
  endtask

  task automatic m_edge();
    for (int k = 0; k < 3; k++) begin
      bit t;
      t = m_tick(k);
      if (ug === 1'b1) m_cnt[k] = 0;
      else if (en === 1'b1) m_cnt[k] = t ? 0 : (m_cnt[k] + 1) & m_msk[k];
      if (t) m_tgl[k] = !m_tgl[k];
      if (m_pre_en[k]) begin
        if (t || ug === 1'b1) begin
          m_sh[k] = m_pre[k];
          m_pend[k] = 0;
        end
        if (we === 1'b1) begin
          m_pre[k] = wd & m_msk[k];
          m_pend[k] = 1;
        end
      end else if (we === 1'b1) begin
        m_sh[k] = wd & m_msk[k];
      end
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 0; we = 0; ug = 0; wd = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_cnt got %0d exp 0", ifa.psc_cnt);
    end
    checks++;
    if (ifa.psc_shadow !== 16'd0) begin
      errors++; $display("FAIL rst_shadow got %0d exp 0", ifa.psc_shadow);
    end
    checks++;
    if (ifa.tgl !== 1'b0) begin
      errors++; $display("FAIL rst_tgl got %b exp 0", ifa.tgl);
    end
    checks++;
    if (ifa.upd_pend !== 1'b0) begin
      errors++; $display("FAIL rst_pend got %b exp 0", ifa.upd_pend);
    end
    checks++;
    if (ifa.tick !== 1'b0) begin
      errors++; $display("FAIL rst_tick got %b exp 0", ifa.tick);
    end
    rst = 1'b1;
  endtask

  task automatic test_div4();
    we = 1; wd = 16'd3;
    clk1();
    we = 0; ug = 1;
    clk1();
    ug = 0; en = 1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (ifa.psc_cnt !== 16'(i % 4)) begin
        errors++; $display("FAIL div4_cnt i=%0d got %0d exp %0d", i, ifa.psc_cnt, i % 4);
      end
      checks++;
      if (ifa.tick !== (i % 4 == 3)) begin
        errors++; $display("FAIL div4_tick i=%0d got %b exp %b", i, ifa.tick, i % 4 == 3);
      end
      checks++;
      if (ifa.tgl !== 1'((i / 4) % 2)) begin
        errors++; $display("FAIL div4_tgl i=%0d got %b exp %0d", i, ifa.tgl, (i / 4) % 2);
      end
      clk1();
    end
  endtask

  task automatic test_preload_update();
    clk1();
    we = 1; wd = 16'd1;
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd1) begin
      errors++; $display("FAIL upd_cnt1 got %0d exp 1", ifa.psc_cnt);
    end
    clk1();
    we = 0;
    #1;
    checks++;
    if (ifa.upd_pend !== 1'b1 || ifa.psc_shadow !== 16'd3) begin
      errors++; $display("FAIL upd_pending got pend=%b sh=%0d exp pend=1 sh=3", ifa.upd_pend, ifa.psc_shadow);
    end
    clk1();
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd3 || ifa.tick !== 1'b1) begin
      errors++; $display("FAIL upd_tick3 got cnt=%0d tick=%b exp cnt=3 tick=1", ifa.psc_cnt, ifa.tick);
    end
    clk1();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ifa.tick !== (i % 2 == 1) || ifa.upd_pend !== 1'b0 || ifa.psc_shadow !== 16'd1) begin
        errors++; $display("FAIL upd_div2 i=%0d got tick=%b pend=%b sh=%0d exp tick=%b pend=0 sh=1", i, ifa.tick, ifa.upd_pend, ifa.psc_shadow, i % 2 == 1);
      end
      clk1();
    end
  endtask

  task automatic test_direct_write();
    en = 0; we = 1; wd = 16'd9; ug = 1;
    clk1();
    we = 0; ug = 0; en = 1;
    repeat (7) clk1();
    #1;
    checks++;
    if (ifb.psc_cnt !== 16'd7 || ifb.psc_shadow !== 16'd9 || ifb.tick !== 1'b0) begin
      errors++; $display("FAIL dir_setup got cnt=%0d sh=%0d tick=%b exp 7 9 0", ifb.psc_cnt, ifb.psc_shadow, ifb.tick);
    end
    checks++;
    if (ifb.upd_pend !== 1'b0) begin
      errors++; $display("FAIL dir_pend got %b exp 0", ifb.upd_pend);
    end
    we = 1; wd = 16'd2;
    clk1();
    we = 0;
    #1;
    checks++;
    if (ifb.psc_cnt !== 16'd8 || ifb.psc_shadow !== 16'd2 || ifb.tick !== 1'b1) begin
      errors++; $display("FAIL dir_shrink got cnt=%0d sh=%0d tick=%b exp 8 2 1", ifb.psc_cnt, ifb.psc_shadow, ifb.tick);
    end
    clk1();
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (ifb.psc_cnt !== 16'(i % 3) || ifb.tick !== (i % 3 == 2)) begin
        errors++; $display("FAIL dir_div3 i=%0d got cnt=%0d tick=%b exp %0d %b", i, ifb.psc_cnt, ifb.tick, i % 3, i % 3 == 2);
      end
      clk1();
    end
  endtask

  task automatic test_hold();
    logic saved;
    en = 0; we = 1; wd = 16'd20;
    clk1();
    we = 0; ug = 1;
    clk1();
    ug = 0; en = 1;
    repeat (5) clk1();
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd5) begin
      errors++; $display("FAIL hold_pre got %0d exp 5", ifa.psc_cnt);
    end
    en = 0;
    saved = ifa.tgl;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (ifa.psc_cnt !== 16'd5 || ifa.tick !== 1'b0 || ifa.tgl !== saved) begin
        errors++; $display("FAIL hold i=%0d got cnt=%0d tick=%b tgl=%b exp 5 0 %b", i, ifa.psc_cnt, ifa.tick, ifa.tgl, saved);
      end
      clk1();
    end
    en = 1;
    clk1();
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd6) begin
      errors++; $display("FAIL hold_resume got %0d exp 6", ifa.psc_cnt);
    end
  endtask

  task automatic test_ug_priority();
    logic saved;
    repeat (14) clk1();
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd20 || ifa.tick !== 1'b1) begin
      errors++; $display("FAIL ug_pre got cnt=%0d tick=%b exp 20 1", ifa.psc_cnt, ifa.tick);
    end
    ug = 1;
    #1;
    checks++;
    if (ifa.tick !== 1'b0) begin
      errors++; $display("FAIL ug_tick got %b exp 0", ifa.tick);
    end
    saved = ifa.tgl;
    clk1();
    ug = 0; en = 0;
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd0 || ifa.tgl !== saved) begin
      errors++; $display("FAIL ug_clear got cnt=%0d tgl=%b exp 0 %b", ifa.psc_cnt, ifa.tgl, saved);
    end
    we = 1; wd = 16'd5; ug = 1;
    clk1();
    we = 0; ug = 0;
    #1;
    checks++;
    if (ifa.psc_shadow !== 16'd20 || ifa.upd_pend !== 1'b1) begin
      errors++; $display("FAIL ug_we got sh=%0d pend=%b exp 20 1", ifa.psc_shadow, ifa.upd_pend);
    end
    ug = 1;
    clk1();
    ug = 0;
    #1;
    checks++;
    if (ifa.psc_shadow !== 16'd5 || ifa.upd_pend !== 1'b0) begin
      errors++; $display("FAIL ug_xfer got sh=%0d pend=%b exp 5 0", ifa.psc_shadow, ifa.upd_pend);
    end
  endtask

  task automatic test_async_reset();
    we = 1; wd = 16'd7;
    clk1();
    we = 0; ug = 1;
    clk1();
    ug = 0; we = 1; wd = 16'd9;
    clk1();
    we = 0; en = 1;
    repeat (3) clk1();
    #1;
    checks++;
    if (ifa.psc_shadow !== 16'd7 || ifa.upd_pend !== 1'b1 || ifa.psc_cnt !== 16'd3) begin
      errors++; $display("FAIL arst_pre got sh=%0d pend=%b cnt=%0d exp 7 1 3", ifa.psc_shadow, ifa.upd_pend, ifa.psc_cnt);
    end
    en = 0;
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if (ifa.psc_cnt !== 16'd0 || ifa.psc_shadow !== 16'd0 || ifa.tgl !== 1'b0 || ifa.upd_pend !== 1'b0 || ifa.tick !== 1'b0) begin
      errors++; $display("FAIL arst_now got cnt=%0d sh=%0d tgl=%b pend=%b tick=%b exp all 0", ifa.psc_cnt, ifa.psc_shadow, ifa.tgl, ifa.upd_pend, ifa.tick);
    end
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ifa.tick !== 1'b1 || ifa.psc_cnt !== 16'd0 || ifa.psc_shadow !== 16'd0) begin
        errors++; $display("FAIL arst_after i=%0d got tick=%b cnt=%0d sh=%0d exp 1 0 0", i, ifa.tick, ifa.psc_cnt, ifa.psc_shadow);
      end
      clk1();
    end
  endtask

  task automatic test_full_range();
    en = 0; we = 1; wd = 16'd15;
    clk1();
    we = 0; ug = 1;
    clk1();
    ug = 0; en = 1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (ifc.tick !== (i % 16 == 15)) begin
        errors++; $display("FAIL full_tick i=%0d got %b exp %b", i, ifc.tick, i % 16 == 15);
      end
      clk1();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en = ($urandom % 4) != 0;
      we = ($urandom % 5) == 0;
      wd = (($urandom % 10) == 0) ? 16'($urandom) : 16'($urandom % 12);
      ug = ($urandom % 16) == 0;
      #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (o_cnt[k] !== 16'(m_cnt[k]) || o_sh[k] !== 16'(m_sh[k]) || o_tick[k] !== m_tick(k) || o_tgl[k] !== m_tgl[k] || o_pend[k] !== m_pend[k]) begin
          errors++;
          $display("FAIL rnd n=%0d k=%0d got cnt=%0d sh=%0d tick=%b tgl=%b pend=%b exp cnt=%0d sh=%0d tick=%b tgl=%b pend=%b", n, k, o_cnt[k], o_sh[k], o_tick[k], o_tgl[k], o_pend[k], m_cnt[k], m_sh[k], m_tick(k), m_tgl[k], m_pend[k]);
        end
      end
      clk1();
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_preload_update();
    test_direct_write();
    test_hold();
    test_ug_priority();
    test_async_reset();
    test_full_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/psc_timebase.md
PSC_TIMEBASE -- requirements
Module: psc_timebase

Interface
REQ-001: Parameter WIDTH, default 16: width of the prescaler counter, preload and shadow registers.
REQ-002: Parameter PRELOAD_EN, default 1: 1 = preload is buffered and transferred at update events; 0 = writes go straight to shadow.
REQ-003: clk  input  1  single rising-edge clock for all state.
REQ-004: rst  input  1  asynchronous, active-low reset.
REQ-005: en  input  1  counter enable; 0 = counter holds.
REQ-006: psc_we  input  1  write strobe for psc_wdata.
REQ-007: psc_wdata  input  WIDTH  new prescaler value; divide ratio = value+1.
REQ-008: ug  input  1  software update generation: clear counter and force preload-to-shadow transfer.
REQ-009: tick  output  1  one-cycle clock-enable pulse at prescaler overflow; not a gated clock.
REQ-010: tgl  output  1  square wave, toggles on every tick.
REQ-011: psc_cnt  output  WIDTH  current counter value.
REQ-012: psc_shadow  output  WIDTH  active prescaler value used for comparison.
REQ-013: upd_pend  output  1  preload written but not yet transferred to shadow.

Function
REQ-014: All state SHALL update on the rising edge of clk only; no output SHALL be derived by ANDing with clk.
REQ-015: tick SHALL be combinational: tick = en & !ug & (psc_cnt >= psc_shadow).
REQ-016: With ug=0 and en=1, psc_cnt SHALL go to 0 when tick=1, else increment by 1 modulo 2^WIDTH.
REQ-017: With ug=0 and en=0, psc_cnt SHALL hold and tick SHALL be 0.
REQ-018: The >= compare SHALL make shadow < psc_cnt (after a shadow decrease) produce a tick and counter clear on the next edge, never a 2^WIDTH run-out.
REQ-019: psc_shadow = 0 SHALL give tick on every enabled cycle (divide by 1); psc_shadow = 2^WIDTH-1 SHALL give divide by 2^WIDTH.
REQ-020: PRELOAD_EN=1: psc_we SHALL load preload register with psc_wdata at the edge; psc_shadow unchanged.
REQ-021: PRELOAD_EN=1: at any edge where tick=1 or ug=1, psc_shadow SHALL load the preload value present before that edge.
REQ-022: PRELOAD_EN=1: upd_pend SHALL set on psc_we, clear on a transfer edge; psc_we coincident with a transfer SHALL leave upd_pend=1 and the new value in preload for the next transfer.
REQ-023: PRELOAD_EN=0: psc_we SHALL load psc_shadow directly at the edge; upd_pend SHALL be constant 0; ug SHALL only clear the counter.
REQ-024: ug=1 SHALL take priority over en: psc_cnt <= 0, tick forced 0, tgl unchanged, regardless of en.
REQ-025: tgl SHALL invert at each edge where tick=1; tgl period = 2*(psc_shadow+1) enabled cycles.

Reset
REQ-026: rst=0 SHALL asynchronously force psc_cnt=0, preload=0, psc_shadow=0, tgl=0, upd_pend=0.
REQ-027: Reset asserted mid-count or with a pending update SHALL discard the pending value; first edge after rst deassertion counts from 0 with shadow 0 (tick=en).

Verification
REQ-028: WIDTH=16, PRELOAD_EN=1; psc_we with 3, then ug, en=1 -> tick every 4th cycle, psc_cnt 0,1,2,3,0; tgl period 8 cycles.
REQ-029: Shadow=3 running; psc_we with 1 at psc_cnt=1 -> upd_pend=1, tick still at cnt=3; thereafter tick every 2nd cycle, upd_pend=0.
REQ-030: PRELOAD_EN=0; shadow=9, psc_cnt=7; psc_we with 2 -> next cycle tick=1, psc_cnt clears to 0, then tick every 3rd cycle.
REQ-031: en=0 at psc_cnt=5 for 10 cycles -> psc_cnt holds 5, tick=0, tgl constant; en=1 resumes at 6.
REQ-032: ug=1 with en=1 at psc_cnt=shadow -> tick=0 that cycle, psc_cnt=0, tgl unchanged; also psc_we+ug same cycle -> shadow gets old preload, upd_pend stays 1.
REQ-033: rst=0 asserted between edges with shadow=7, upd_pend=1 -> all outputs 0 immediately; after release, en=1 gives tick every cycle.
